pipeline_mem: RTL

Memory-access stage of the 5-stage pipeline, between the EX/MEM and MEM/WB boundaries. It passes ALU results through, performs loads and stores over a single-outstanding req/ack data bus, and produces the MEM-stage forwarding triple (`ce_forward_mem`, `reg_forward_mem`, `data_forward_mem`) consumed by `pipeline_id`. While a memory access is pending it raises `stall_req` so that upstream stages hold.

---
 rtl/pipeline_mem_pkg.sv | 54 +++++
 rtl/pipeline_mem_if.sv | 25 ++
 rtl/pipeline_mem_align.sv | 59 +++++
 rtl/pipeline_mem.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipeline_mem_pkg.sv
// Shared widths, memory-op encodings and FSM states for the MEM stage.
// Pure declarations and helper functions; no timing of its own.
// No flow control here; consumers decide how the helpers gate their handshakes.
package pipeline_mem_pkg;

  localparam int COMMON_WIDTH  = 32;
  localparam int REG_NUM_WIDTH = 5;
  localparam int MEM_OP_WIDTH  = 4;

  typedef logic [MEM_OP_WIDTH-1:0] mem_op_t;

  localparam mem_op_t MEM_OP_NONE = 4'd0;
  localparam mem_op_t MEM_OP_LB   = 4'd1;
  localparam mem_op_t MEM_OP_LH   = 4'd2;
  localparam mem_op_t MEM_OP_LW   = 4'd3;
  localparam mem_op_t MEM_OP_LBU  = 4'd4;
  localparam mem_op_t MEM_OP_LHU  = 4'd5;
  localparam mem_op_t MEM_OP_SB   = 4'd6;
  localparam mem_op_t MEM_OP_SH   = 4'd7;
  localparam mem_op_t MEM_OP_SW   = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  function automatic logic is_load_op(input mem_op_t op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
           (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
  endfunction

  function automatic logic is_store_op(input mem_op_t op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  // Unused encodings fall through as plain ALU entries.
  function automatic logic is_mem_op(input mem_op_t op);
    return is_load_op(op) || is_store_op(op);
  endfunction

  function automatic logic is_half_op(input mem_op_t op);
    return (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
  endfunction

  function automatic logic is_word_op(input mem_op_t op);
    return (op == MEM_OP_LW) || (op == MEM_OP_SW);
  endfunction

  // Halfword needs addr[0]==0, word needs addr[1:0]==0.
  function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lo);
    return (is_half_op(op) && lo[0]) || (is_word_op(op) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/pipeline_mem_if.sv
// Single-outstanding req/ack data bus between the MEM stage and memory.
// Request held until ack; read data valid in the ack cycle.
// Backpressure is the ack itself: the master waits as long as ack stays low.
interface pipeline_mem_if
  import pipeline_mem_pkg::*;
;
  logic                    mem_req;
  logic                    mem_we;
  logic [COMMON_WIDTH-1:0] mem_addr;
  logic [COMMON_WIDTH-1:0] mem_wdata;
  logic [3:0]              mem_wstrb;
  logic                    mem_ack;
  logic [COMMON_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/pipeline_mem_align.sv
// Lane steering: store strobe/replication and load lane select/extension.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs in the same cycle.
module mem_align
  import pipeline_mem_pkg::*;
(
  input  mem_op_t                 st_op,
  input  logic [1:0]              st_lo,
  input  logic [COMMON_WIDTH-1:0] st_data,
  output logic [3:0]              st_wstrb,
  output logic [COMMON_WIDTH-1:0] st_wdata,
  input  mem_op_t                 ld_op,
  input  logic [1:0]              ld_lo,
  input  logic [COMMON_WIDTH-1:0] ld_rdata,
  output logic [COMMON_WIDTH-1:0] ld_data
);

  logic [COMMON_WIDTH-1:0] byte_shift;
  logic [COMMON_WIDTH-1:0] half_shift;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;

  // Store side: halfwords only look at addr[1], words ignore the low bits.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = '0;
    case (st_op)
      MEM_OP_SB: begin
        st_wstrb = 4'b0001 << st_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_OP_SH: begin
        st_wstrb = 4'b0011 << {st_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      MEM_OP_SW: begin
        st_wstrb = 4'b1111;
        st_wdata = st_data;
      end
      default: ;
    endcase
  end

  // Load side: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    byte_shift = ld_rdata >> {ld_lo, 3'b000};
    half_shift = ld_rdata >> {ld_lo[1], 4'b0000};
    ld_byte    = byte_shift[7:0];
    ld_half    = half_shift[15:0];
    case (ld_op)
      MEM_OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_OP_LBU: ld_data = {24'h0, ld_byte};
      MEM_OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_OP_LHU: ld_data = {16'h0, ld_half};
      default:    ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/pipeline_mem.sv
// MEM stage: ALU pass-through, single-outstanding load/store, forwarding triple. Option: MEM_MISALIGN_TRAP_EN.
// ALU result in N+1; memory result one cycle after ack (earliest N+2).
// stall_req is combinational: high in the issue cycle and in WAIT until ack.
module pipeline_mem
  import pipeline_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce_in,
  input  logic [REG_NUM_WIDTH-1:0] rd_in,
  input  logic                     wb_en_in,
  input  logic [COMMON_WIDTH-1:0]  alu_result,
  input  mem_op_t                  mem_op,
  input  logic [COMMON_WIDTH-1:0]  store_data,
  pipeline_mem_if.master           bus,
  output logic                     stall_req,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                     misalign_err,
`endif
  output logic                     ce_wb,
  output logic [REG_NUM_WIDTH-1:0] reg_wb,
  output logic [COMMON_WIDTH-1:0]  data_wb,
  output logic                     ce_forward_mem,
  output logic [REG_NUM_WIDTH-1:0] reg_forward_mem,
  output logic [COMMON_WIDTH-1:0]  data_forward_mem
);

  mem_state_t               state;
  mem_op_t                  op_q;
  logic [1:0]               addr_lo_q;
  logic [REG_NUM_WIDTH-1:0] rd_q;
  logic                     wb_en_q;

  logic                     req_q;
  logic                     we_q;
  logic [COMMON_WIDTH-1:0]  maddr_q;
  logic [COMMON_WIDTH-1:0]  wdata_q;
  logic [3:0]               wstrb_q;

  logic                     ce_wb_q;
  logic [REG_NUM_WIDTH-1:0] reg_wb_q;
  logic [COMMON_WIDTH-1:0]  data_wb_q;

  logic [3:0]               st_wstrb;
  logic [COMMON_WIDTH-1:0]  st_wdata;
  logic [COMMON_WIDTH-1:0]  ld_data;
  logic                     issue;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_in;
  logic mis_q;
  assign mis_in       = op_misaligned(mem_op, alu_result[1:0]);
  // A trapped access never reaches the bus, so it must not stall either.
  assign issue        = (state == ST_IDLE) && ce_in && is_mem_op(mem_op) && !mis_in;
  assign misalign_err = mis_q;
`else
  assign issue        = (state == ST_IDLE) && ce_in && is_mem_op(mem_op);
`endif

  assign stall_req = issue || ((state == ST_WAIT) && !bus.mem_ack);

  // Store steering works on the live inputs (registered at issue);
  // load steering works on the captured op/address against the bus data.
  mem_align u_align (
    .st_op    (mem_op),
    .st_lo    (alu_result[1:0]),
    .st_data  (store_data),
    .st_wstrb (st_wstrb),
    .st_wdata (st_wdata),
    .ld_op    (op_q),
    .ld_lo    (addr_lo_q),
    .ld_rdata (bus.mem_rdata),
    .ld_data  (ld_data)
  );

  // Stage FSM: captures accesses, drives the bus, retires into MEM/WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= MEM_OP_NONE;
      addr_lo_q <= 2'b00;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      ce_wb_q   <= 1'b0;
      reg_wb_q  <= '0;
      data_wb_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      ce_wb_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (ce_in) begin
            if (!is_mem_op(mem_op)) begin
              ce_wb_q   <= wb_en_in && (rd_in != '0);
              reg_wb_q  <= rd_in;
              data_wb_q <= alu_result;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (mis_in) begin
              mis_q <= 1'b1;
            end
`endif
            else begin
              state     <= ST_WAIT;
              op_q      <= mem_op;
              addr_lo_q <= alu_result[1:0];
              rd_q      <= rd_in;
              wb_en_q   <= wb_en_in;
              req_q     <= 1'b1;
              we_q      <= is_store_op(mem_op);
              maddr_q   <= {alu_result[COMMON_WIDTH-1:2], 2'b00};
              wdata_q   <= st_wdata;
              wstrb_q   <= st_wstrb;
            end
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            state <= ST_IDLE;
            req_q <= 1'b0;
            if (is_load_op(op_q)) begin
              ce_wb_q   <= wb_en_q && (rd_q != '0);
              reg_wb_q  <= rd_q;
              data_wb_q <= ld_data;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  assign ce_wb            = ce_wb_q;
  assign reg_wb           = reg_wb_q;
  assign data_wb          = data_wb_q;
  assign ce_forward_mem   = ce_wb_q;
  assign reg_forward_mem  = reg_wb_q;
  assign data_forward_mem = data_wb_q;

endmodule
